retire_sched: RTL

RETIRE_SCHED -- requirements
Module: retire_sched

---
 rtl/sched_pkg.sv | 26 ++
 rtl/retire_wdog.sv | 28 ++
 rtl/retire_sched.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sched_pkg.sv
// Shared types and defaults for the dual-core retire scheduler.
package sched_pkg;

   localparam int unsigned SCHED_CNT_W   = 8;
   localparam int unsigned SCHED_TIMEOUT = 32;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_WAIT1 = 3'd2,
      S_WAIT2 = 3'd3,
      S_DONE  = 3'd4,
      S_TOUT  = 3'd5
   } sched_state_e;

   // Core clock enables {en_1, en_2} implied by a scheduler state.
   function automatic logic [1:0] sched_en(input sched_state_e s);
      case (s)
         S_RUN:   sched_en = 2'b11;
         S_WAIT1: sched_en = 2'b10;
         S_WAIT2: sched_en = 2'b01;
         default: sched_en = 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/retire_wdog.sv
// Watchdog counting cycles without a retire-pair; flags the cycle it would reach TIMEOUT.
module retire_wdog #(
   parameter int unsigned TIMEOUT = 32
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic cnt_en_i,
   output logic expired_c
);

   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (cnt_en_i) begin
         cnt_q <= cnt_q + WD_W'(1);
      end
   end

   assign expired_c = cnt_en_i && !clear_i && (cnt_q == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/retire_sched.sv
// Lockstep retire scheduler: gates two core clocks so retirements complete in pairs.
module retire_sched
   import sched_pkg::*;
#(
   parameter int unsigned CNT_W   = SCHED_CNT_W,
   parameter int unsigned TIMEOUT = SCHED_TIMEOUT
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [CNT_W-1:0] max_retire_i,
   input  logic             retire_1_i,
   input  logic             retire_2_i,
   output logic             en_1_o,
   output logic             en_2_o,
   output logic             retire_o,
   output logic [CNT_W-1:0] pair_cnt_o,
   output logic             finished_o,
   output logic             timeout_o
);

   sched_state_e     state_q;
   sched_state_e     state_d;
   logic [CNT_W-1:0] budget_q;
   logic [CNT_W-1:0] cnt_inc;
   logic             q1;
   logic             q2;
   logic             pair_done;
   logic             start_ok;
   logic             wd_en;
   logic             wd_clr;
   logic             wd_exp_c;
   logic [1:0]       en_d;

   // Retires only count while the matching core is enabled; abort masks everything.
   always_comb begin
      q1        = 1'b0;
      q2        = 1'b0;
      pair_done = 1'b0;
      start_ok  = 1'b0;
      wd_en     = 1'b0;
      if (!abort_i) begin
         q1 = retire_1_i && (state_q == S_RUN || state_q == S_WAIT1);
         q2 = retire_2_i && (state_q == S_RUN || state_q == S_WAIT2);
         case (state_q)
            S_IDLE:  start_ok  = start_i;
            S_RUN:   pair_done = q1 && q2;
            S_WAIT1: pair_done = q1;
            S_WAIT2: pair_done = q2;
            default: ;
         endcase
         wd_en = !pair_done &&
                 (state_q == S_RUN || state_q == S_WAIT1 || state_q == S_WAIT2);
      end
   end

   assign wd_clr  = pair_done || start_ok || abort_i;
   assign cnt_inc = (pair_cnt_o == '1) ? pair_cnt_o : pair_cnt_o + CNT_W'(1);

   retire_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (wd_clr),
      .cnt_en_i  (wd_en),
      .expired_c (wd_exp_c)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Pair completion outranks watchdog expiry; abort outranks both.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               state_d = (max_retire_i == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (q1 && !q2) begin
               state_d = S_WAIT2;
            end else if (q2 && !q1) begin
               state_d = S_WAIT1;
            end
         end
         default: ;
      endcase
      if (pair_done) begin
         state_d = (cnt_inc == budget_q) ? S_DONE : S_RUN;
      end else if (wd_exp_c) begin
         state_d = S_TOUT;
      end
      if (abort_i) begin
         state_d = S_IDLE;
      end
   end

   assign en_d = sched_en(state_d);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         en_1_o     <= 1'b0;
         en_2_o     <= 1'b0;
         retire_o   <= 1'b0;
         finished_o <= 1'b0;
         timeout_o  <= 1'b0;
         pair_cnt_o <= '0;
         budget_q   <= '0;
      end else begin
         en_1_o     <= en_d[1];
         en_2_o     <= en_d[0];
         retire_o   <= pair_done;
         finished_o <= (state_d == S_DONE);
         timeout_o  <= (state_d == S_TOUT);
         if (start_ok) begin
            pair_cnt_o <= '0;
            budget_q   <= max_retire_i;
         end else if (pair_done) begin
            pair_cnt_o <= cnt_inc;
         end
      end
   end

endmodule
